// File: rtl/freq_band_classifier.sv
// Classifies averaged period measurements into programmable bands, committing a
// new band only after CONFIRM agreeing samples, and flags loss of measurements.
module freq_band_classifier #(
  parameter int NUM_BANDS   = 4,
  parameter int CONFIRM     = 3,
  parameter int TIMEOUT_CYC = 1000000
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [31:0] period_in,
  input  logic        period_valid,
  input  logic        cfg_we,
  input  logic [3:0]  cfg_addr,
  input  logic [31:0] cfg_lo,
  input  logic [31:0] cfg_hi,
  output logic [3:0]  band,
  output logic        band_locked,
  output logic        band_change,
  output logic        no_signal
);

  localparam logic [3:0]      NONE      = 4'hF;
  localparam int              WD_W      = $clog2(TIMEOUT_CYC + 1);
  localparam logic [WD_W-1:0] WD_MAX    = WD_W'(TIMEOUT_CYC);
  localparam logic [WD_W-1:0] WD_TRIP   = WD_W'(TIMEOUT_CYC - 1);
  localparam logic [7:0]      CONFIRM_N = 8'(CONFIRM);

  typedef enum logic [1:0] {HUNT, CONFIRMING, LOCKED} state_t;

  logic [31:0]     lo [NUM_BANDS];
  logic [31:0]     hi [NUM_BANDS];
  logic [3:0]      match;
  logic [3:0]      match_p1;
  logic            vld_p1;
  state_t          state;
  logic [3:0]      cand;
  logic [7:0]      count;
  logic [WD_W-1:0] wd;
  logic            timeout;

  // Threshold bank; all-disabled after reset (lo above hi for every band).
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_BANDS; i++) begin
        lo[i] <= '1;
        hi[i] <= '0;
      end
    end else if (cfg_we) begin
      for (int i = 0; i < NUM_BANDS; i++) begin
        if (cfg_addr == 4'(i)) begin
          lo[i] <= cfg_lo;
          hi[i] <= cfg_hi;
        end
      end
    end
  end

  // Lowest matching index wins, so scan from the top and let lower indices override.
  always_comb begin
    match = NONE;
    for (int i = NUM_BANDS - 1; i >= 0; i--) begin
      if (period_in >= lo[i] && period_in <= hi[i]) match = 4'(i);
    end
    if (period_in == 32'd0) match = NONE;
  end

  // ---- stage 1: registered classification
  always_ff @(posedge clk) begin
    if (!reset_n) vld_p1 <= 1'b0;
    else          vld_p1 <= period_valid;
  end

  always_ff @(posedge clk) begin
    if (period_valid) match_p1 <= match;
  end

  assign timeout     = !period_valid && (wd == WD_TRIP);
  assign band_locked = (band != NONE);

  // ---- stage 2: confirmation FSM and watchdog; timeout overrides any commit
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state       <= HUNT;
      cand        <= NONE;
      count       <= 8'd0;
      band        <= NONE;
      band_change <= 1'b0;
      no_signal   <= 1'b0;
      wd          <= '0;
    end else begin
      band_change <= 1'b0;
      if (period_valid)       wd <= '0;
      else if (wd != WD_MAX)  wd <= wd + 1'b1;

      if (period_valid) no_signal <= 1'b0;
      else if (timeout) no_signal <= 1'b1;

      if (timeout) begin
        state       <= HUNT;
        count       <= 8'd0;
        band        <= NONE;
        band_change <= (band != NONE);
      end else if (vld_p1) begin
        if (match_p1 == band) begin
          state <= (band == NONE) ? HUNT : LOCKED;
          count <= 8'd0;
        end else if (state != CONFIRMING || match_p1 != cand) begin
          cand <= match_p1;
          if (CONFIRM_N == 8'd1) begin
            band        <= match_p1;
            band_change <= 1'b1;
            state       <= (match_p1 == NONE) ? HUNT : LOCKED;
            count       <= 8'd0;
          end else begin
            count <= 8'd1;
            state <= CONFIRMING;
          end
        end else if (count + 8'd1 == CONFIRM_N) begin
          band        <= cand;
          band_change <= 1'b1;
          state       <= (cand == NONE) ? HUNT : LOCKED;
          count       <= 8'd0;
        end else begin
          count <= count + 8'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_freq_band_classifier.sv
// Directed bench for freq_band_classifier: a default-timeout instance for band
// behaviour and a TIMEOUT_CYC=50 instance for the loss-of-signal path.
module tb_freq_band_classifier;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset_n;
  logic [31:0] period_in;
  logic        period_valid;
  logic        cfg_we;
  logic [3:0]  cfg_addr;
  logic [31:0] cfg_lo;
  logic [31:0] cfg_hi;
  logic [3:0]  band, band_t;
  logic        band_locked, band_locked_t;
  logic        band_change, band_change_t;
  logic        no_signal, no_signal_t;

  int n_cmp = 0;
  int n_bad = 0;

  freq_band_classifier dut (
    .clk(clk), .reset_n(reset_n), .period_in(period_in), .period_valid(period_valid),
    .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_lo(cfg_lo), .cfg_hi(cfg_hi),
    .band(band), .band_locked(band_locked), .band_change(band_change), .no_signal(no_signal)
  );

  freq_band_classifier #(.TIMEOUT_CYC(50)) dut_to (
    .clk(clk), .reset_n(reset_n), .period_in(period_in), .period_valid(period_valid),
    .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_lo(cfg_lo), .cfg_hi(cfg_hi),
    .band(band_t), .band_locked(band_locked_t), .band_change(band_change_t),
    .no_signal(no_signal_t)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input int n);
    reset_n = 1'b0;
    tick(n);
    reset_n = 1'b1;
  endtask

  task automatic cfg_write(input logic [3:0] a, input logic [31:0] l, input logic [31:0] h);
    cfg_we = 1'b1; cfg_addr = a; cfg_lo = l; cfg_hi = h;
    tick(1);
    cfg_we = 1'b0;
  endtask

  task automatic strobe(input logic [31:0] p);
    period_in = p; period_valid = 1'b1;
    tick(1);
    period_valid = 1'b0;
  endtask

  // Sends one sample and checks the outputs two edges after the strobe was presented.
  task automatic sample(input string tag, input bit use_t, input logic [31:0] p,
                        input logic exp_chg, input logic [3:0] exp_band, input int gap);
    strobe(p);
    tick(1);
    if (use_t) begin
      chk({tag, "_chg"}, band_change_t, exp_chg);
      chk({tag, "_band"}, band_t, exp_band);
    end else begin
      chk({tag, "_chg"}, band_change, exp_chg);
      chk({tag, "_band"}, band, exp_band);
    end
    tick(gap);
  endtask

  initial begin
    period_in = '0; period_valid = 1'b0;
    cfg_we = 1'b0; cfg_addr = '0; cfg_lo = '0; cfg_hi = '0;
    reset_n = 1'b0;
    tick(3);
    reset_n = 1'b1;
    tick(1);
    chk("rst_band", band, 4'hF);
    chk("rst_locked", band_locked, 1'b0);
    chk("rst_chg", band_change, 1'b0);
    chk("rst_nosig", no_signal, 1'b0);
    chk("rst_nosig_t", no_signal_t, 1'b0);

    // Basic lock on band 0 with 100-cycle strobe spacing
    cfg_write(4'd0, 32'd900, 32'd1100);
    cfg_write(4'd1, 32'd1900, 32'd2100);
    sample("lock_s1", 0, 32'd1000, 1'b0, 4'hF, 98);
    sample("lock_s2", 0, 32'd1000, 1'b0, 4'hF, 98);
    sample("lock_s3", 0, 32'd1000, 1'b1, 4'h0, 0);
    chk("lock_locked", band_locked, 1'b1);
    tick(1);
    chk("lock_pulse_end", band_change, 1'b0);

    // Interrupted confirmation, then a clean run to band 1
    sample("hyst_a", 0, 32'd2000, 1'b0, 4'h0, 3);
    sample("hyst_b", 0, 32'd2000, 1'b0, 4'h0, 3);
    sample("hyst_c", 0, 32'd1000, 1'b0, 4'h0, 3);
    sample("hyst_d", 0, 32'd2000, 1'b0, 4'h0, 3);
    sample("hyst_e", 0, 32'd2000, 1'b0, 4'h0, 3);
    sample("hyst_f", 0, 32'd2000, 1'b1, 4'h1, 3);

    // Overlapping windows: lowest index wins; zero period always NONE
    cfg_write(4'd0, 32'd0, 32'd5000);
    cfg_write(4'd1, 32'd1000, 32'd2000);
    sample("ovl_a", 0, 32'd1500, 1'b0, 4'h1, 3);
    sample("ovl_b", 0, 32'd1500, 1'b0, 4'h1, 3);
    sample("ovl_c", 0, 32'd1500, 1'b1, 4'h0, 3);
    sample("zero_a", 0, 32'd0, 1'b0, 4'h0, 3);
    sample("zero_b", 0, 32'd0, 1'b0, 4'h0, 3);
    sample("zero_c", 0, 32'd0, 1'b1, 4'hF, 0);
    chk("zero_locked", band_locked, 1'b0);

    // Timeout on the TIMEOUT_CYC=50 instance
    do_reset(2);
    cfg_write(4'd1, 32'd1900, 32'd2100);
    sample("to_lock_a", 1, 32'd2000, 1'b0, 4'hF, 3);
    sample("to_lock_b", 1, 32'd2000, 1'b0, 4'hF, 3);
    sample("to_lock_c", 1, 32'd2000, 1'b1, 4'h1, 48);
    chk("to_before", no_signal_t, 1'b0);
    chk("to_before_band", band_t, 4'h1);
    tick(1);
    chk("to_nosig", no_signal_t, 1'b1);
    chk("to_band", band_t, 4'hF);
    chk("to_chg", band_change_t, 1'b1);
    chk("to_locked", band_locked_t, 1'b0);
    tick(3);
    chk("to_hold", no_signal_t, 1'b1);
    chk("to_chg_end", band_change_t, 1'b0);
    strobe(32'd2000);
    chk("to_clear", no_signal_t, 1'b0);
    tick(1);
    chk("to_r1_band", band_t, 4'hF);
    tick(3);
    sample("to_r2", 1, 32'd2000, 1'b0, 4'hF, 3);
    sample("to_r3", 1, 32'd2000, 1'b1, 4'h1, 3);

    // Config write coincident with a sample; out-of-range address ignored
    do_reset(2);
    cfg_we = 1'b1; cfg_addr = 4'd0; cfg_lo = 32'd100; cfg_hi = 32'd200;
    period_in = 32'd150; period_valid = 1'b1;
    tick(1);
    cfg_we = 1'b0; period_valid = 1'b0;
    tick(1);
    chk("cw_same_chg", band_change, 1'b0);
    chk("cw_same_band", band, 4'hF);
    tick(3);
    sample("cw_a", 0, 32'd150, 1'b0, 4'hF, 3);
    sample("cw_b", 0, 32'd150, 1'b0, 4'hF, 3);
    sample("cw_c", 0, 32'd150, 1'b1, 4'h0, 3);
    cfg_write(4'd9, 32'd5000, 32'd6000);
    sample("bad_addr_a", 0, 32'd5500, 1'b0, 4'h0, 3);
    sample("bad_addr_b", 0, 32'd5500, 1'b0, 4'h0, 3);
    sample("bad_addr_c", 0, 32'd5500, 1'b1, 4'hF, 3);

    // Reset while confirming with count 2
    cfg_write(4'd0, 32'd900, 32'd1100);
    sample("mid_a", 0, 32'd1000, 1'b0, 4'hF, 1);
    sample("mid_b", 0, 32'd1000, 1'b0, 4'hF, 0);
    do_reset(1);
    chk("mid_rst_band", band, 4'hF);
    chk("mid_rst_locked", band_locked, 1'b0);
    chk("mid_rst_chg", band_change, 1'b0);
    chk("mid_rst_nosig", no_signal, 1'b0);
    tick(2);
    sample("post_a", 0, 32'd1000, 1'b0, 4'hF, 3);
    sample("post_b", 0, 32'd1000, 1'b0, 4'hF, 3);
    sample("post_c", 0, 32'd1000, 1'b0, 4'hF, 3);
    chk("post_locked", band_locked, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
